// File: rtl/dds_pkg.sv
// Shared types and default constants for the DDS tuning controller.
// Request codes, FSM states, default step sizes and the request priority helpers.
package dds_pkg;

  typedef enum logic [3:0] {
    NONE, C_UP, C_DN, M_UP, M_DN, N_UP, N_DN, P_UP, P_DN
  } req_code_e;

  typedef enum logic [1:0] {
    IDLE, HOLD, REPEAT
  } state_e;

  localparam logic [31:0] DEF_FTW_RESET   = 32'd42950;
  localparam logic [31:0] DEF_FTW_MIN     = 32'd1;
  localparam logic [31:0] DEF_FTW_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] DEF_STEP_COARSE = 32'd4294967;
  localparam logic [31:0] DEF_STEP_MICRO  = 32'd42950;
  localparam logic [31:0] DEF_STEP_NANO   = 32'd430;
  localparam logic [31:0] DEF_PHASE_STEP  = 32'h0400_0000;
  localparam logic [23:0] DEF_HOLD_CYC    = 24'd5_000_000;
  localparam logic [23:0] DEF_REP_CYC     = 24'd1_000_000;

  // Active-high request vector bit order: coarse up/down, micro up/down,
  // nano up/down, phase up/down, bit 0 being the highest priority.
  function automatic req_code_e req_select(input logic [7:0] act);
    if      (act[0]) return C_UP;
    else if (act[1]) return C_DN;
    else if (act[2]) return M_UP;
    else if (act[3]) return M_DN;
    else if (act[4]) return N_UP;
    else if (act[5]) return N_DN;
    else if (act[6]) return P_UP;
    else if (act[7]) return P_DN;
    else             return NONE;
  endfunction

  function automatic logic req_hit(input req_code_e code, input logic [7:0] act);
    case (code)
      C_UP:    return act[0];
      C_DN:    return act[1];
      M_UP:    return act[2];
      M_DN:    return act[3];
      N_UP:    return act[4];
      N_DN:    return act[5];
      P_UP:    return act[6];
      P_DN:    return act[7];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dds_step_alu.sv
// Combinational step unit: applies one request code to the current words,
// saturating the frequency word and wrapping the phase word.
module dds_step_alu
  import dds_pkg::*;
#(
  parameter int             W           = 32,
  parameter logic [W-1:0]   FTW_MIN     = DEF_FTW_MIN,
  parameter logic [W-1:0]   FTW_MAX     = DEF_FTW_MAX,
  parameter logic [W-1:0]   STEP_COARSE = DEF_STEP_COARSE,
  parameter logic [W-1:0]   STEP_MICRO  = DEF_STEP_MICRO,
  parameter logic [W-1:0]   STEP_NANO   = DEF_STEP_NANO,
  parameter logic [W-1:0]   PHASE_STEP  = DEF_PHASE_STEP
) (
  input  req_code_e      code_i,
  input  logic [W-1:0]   freq_i,
  input  logic [W-1:0]   phase_i,
  output logic [W-1:0]   freq_o,
  output logic [W-1:0]   phase_o,
  output logic           changed_o
);

  logic [W-1:0] fstep;
  logic         is_up;
  logic         is_dn;
  logic [W:0]   sum;
  logic [W:0]   diff;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    fstep = '0;
    is_up = 1'b0;
    is_dn = 1'b0;
    case (code_i)
      C_UP:    begin fstep = STEP_COARSE; is_up = 1'b1; end
      C_DN:    begin fstep = STEP_COARSE; is_dn = 1'b1; end
      M_UP:    begin fstep = STEP_MICRO;  is_up = 1'b1; end
      M_DN:    begin fstep = STEP_MICRO;  is_dn = 1'b1; end
      N_UP:    begin fstep = STEP_NANO;   is_up = 1'b1; end
      N_DN:    begin fstep = STEP_NANO;   is_dn = 1'b1; end
      default: ;
    endcase

    // The extra bit catches both carry-out on add and borrow on subtract.
    sum  = {1'b0, freq_i} + {1'b0, fstep};
    diff = {1'b0, freq_i} - {1'b0, fstep};

    freq_o = freq_i;
    if (is_up)
      freq_o = (sum > {1'b0, FTW_MAX}) ? FTW_MAX : sum[W-1:0];
    else if (is_dn)
      freq_o = (diff[W] || (diff[W-1:0] < FTW_MIN)) ? FTW_MIN : diff[W-1:0];

    phase_o = phase_i;
    if (code_i == P_UP)
      phase_o = phase_i + PHASE_STEP;
    else if (code_i == P_DN)
      phase_o = phase_i - PHASE_STEP;

    changed_o = (freq_o != freq_i) || (phase_o != phase_i);
  end

endmodule

// File: rtl/dds_tune_ctrl.sv
// Push-button to DDS tuning word controller: registered requests, press-and-hold
// auto-repeat FSM, and registered frequency/phase words with an update strobe.
module dds_tune_ctrl
  import dds_pkg::*;
#(
  parameter int             W           = 32,
  parameter logic [W-1:0]   FTW_RESET   = DEF_FTW_RESET,
  parameter logic [W-1:0]   FTW_MIN     = DEF_FTW_MIN,
  parameter logic [W-1:0]   FTW_MAX     = DEF_FTW_MAX,
  parameter logic [W-1:0]   STEP_COARSE = DEF_STEP_COARSE,
  parameter logic [W-1:0]   STEP_MICRO  = DEF_STEP_MICRO,
  parameter logic [W-1:0]   STEP_NANO   = DEF_STEP_NANO,
  parameter logic [W-1:0]   PHASE_STEP  = DEF_PHASE_STEP,
  parameter logic [23:0]    HOLD_CYC    = DEF_HOLD_CYC,
  parameter logic [23:0]    REP_CYC     = DEF_REP_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Switchadd,
  input  logic         Switchsub,
  input  logic         SwitchMicroadd,
  input  logic         SwitchMicrosub,
  input  logic         SwitchNanoadd,
  input  logic         SwitchNanosub,
  input  logic         Phaseadd,
  input  logic         Phasesub,
  output logic [W-1:0] FreqWord,
  output logic [W-1:0] PhaseWord,
  output logic         Update,
  output logic         Saturated
);

  logic [7:0]   req_n_q;
  logic [7:0]   act;
  req_code_e    sel;
  state_e       state_q, state_d;
  logic [23:0]  cnt_q, cnt_d;
  req_code_e    code_q, code_d;
  logic         step_en;
  req_code_e    step_code;
  logic [W-1:0] freq_q, freq_d, phase_q, phase_d, alu_freq, alu_phase;
  logic         upd_q, upd_d, sat_q, sat_d, alu_changed;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_n_q <= '1;
    else       req_n_q <= {Phasesub, Phaseadd, SwitchNanosub, SwitchNanoadd,
                           SwitchMicrosub, SwitchMicroadd, Switchsub, Switchadd};
  end

  assign act = ~req_n_q;
  assign sel = req_select(act);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // While a code is latched, other requests are ignored until it is released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (sel != NONE) begin
        state_d = HOLD;
        cnt_d   = HOLD_CYC - 24'd1;
        code_d  = sel;
      end
      HOLD, REPEAT: begin
        if (!req_hit(code_q, act)) begin
          state_d = IDLE;
          cnt_d   = '0;
          code_d  = NONE;
        end else if (cnt_q == '0) begin
          state_d = REPEAT;
          cnt_d   = REP_CYC - 24'd1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_en   = 1'b0;
    step_code = NONE;
    case (state_q)
      IDLE: if (sel != NONE) begin
        step_en   = 1'b1;
        step_code = sel;
      end
      HOLD, REPEAT: if (req_hit(code_q, act) && (cnt_q == '0)) begin
        step_en   = 1'b1;
        step_code = code_q;
      end
      default: ;
    endcase
  end

  dds_step_alu #(
    .W(W), .FTW_MIN(FTW_MIN), .FTW_MAX(FTW_MAX), .STEP_COARSE(STEP_COARSE),
    .STEP_MICRO(STEP_MICRO), .STEP_NANO(STEP_NANO), .PHASE_STEP(PHASE_STEP)
  ) u_alu (
    .code_i   (step_code),
    .freq_i   (freq_q),
    .phase_i  (phase_q),
    .freq_o   (alu_freq),
    .phase_o  (alu_phase),
    .changed_o(alu_changed)
  );

  assign freq_d  = step_en ? alu_freq  : freq_q;
  assign phase_d = step_en ? alu_phase : phase_q;
  assign upd_d   = step_en & alu_changed;
  assign sat_d   = (freq_d == FTW_MIN) || (freq_d == FTW_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_q  <= FTW_RESET;
      phase_q <= '0;
      upd_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      freq_q  <= freq_d;
      phase_q <= phase_d;
      upd_q   <= upd_d;
      sat_q   <= sat_d;
    end
  end

  assign FreqWord  = freq_q;
  assign PhaseWord = phase_q;
  assign Update    = upd_q;
  assign Saturated = sat_q;

endmodule

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
- Downstream consumer of the debounced push-button decoder.
- Turns its active-low step requests (coarse/micro/nano frequency up/down, phase up/down) into a registered 32-bit frequency tuning word and a 32-bit phase offset word for the DDS phase accumulator.
- Adds press-and-hold auto-repeat, saturating frequency arithmetic and a one-cycle update strobe so the accumulator latches new words cleanly.

Parameters:
- W, 32, tuning and phase word width.
- FTW_RESET, 32'd42950, frequency word after reset.
- FTW_MIN, 32'd1, lower saturation bound.
- FTW_MAX, 32'h7FFF_FFFF, upper saturation bound (Nyquist).
- STEP_COARSE, 32'd4294967, coarse step.
- STEP_MICRO, 32'd42950, micro step.
- STEP_NANO, 32'd430, nano step.
- PHASE_STEP, 32'h0400_0000, phase step (1/64 turn).
- HOLD_CYC, 24'd5_000_000, cycles held before auto-repeat starts.
- REP_CYC, 24'd1_000_000, cycles between repeats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- Switchadd  in  1  coarse up request, active-low
- Switchsub  in  1  coarse down request, active-low
- SwitchMicroadd  in  1  micro up request, active-low
- SwitchMicrosub  in  1  micro down request, active-low
- SwitchNanoadd  in  1  nano up request, active-low
- SwitchNanosub  in  1  nano down request, active-low
- Phaseadd  in  1  phase up request, active-low
- Phasesub  in  1  phase down request, active-low
- FreqWord  out  W  registered frequency tuning word
- PhaseWord  out  W  registered phase offset word
- Update  out  1  one-cycle pulse when FreqWord or PhaseWord changed
- Saturated  out  1  high while FreqWord equals FTW_MIN or FTW_MAX

Behaviour:
- Reset (async, high): FreqWord=FTW_RESET, PhaseWord=0, Update=0, Saturated=0, FSM=IDLE, counter=0, input register all 1s.
- Input stage: the eight requests are registered once (inverted to active-high internally). All decisions use the registered copy.
- Request select: when several requests are active in the same cycle, one code is chosen by fixed priority: Switchadd > Switchsub > Micro add > Micro sub > Nano add > Nano sub > Phaseadd > Phasesub. Lower-priority requests are ignored.
- FSM states and transitions:
  - IDLE: any active request -> apply the selected step, load counter=HOLD_CYC-1, latch the code -> HOLD.
  - HOLD: latched code still active -> counter decrements; at 0 apply the step, load REP_CYC-1 -> REPEAT. Latched code released -> IDLE.
  - REPEAT: same as HOLD but reloads REP_CYC-1 after each step. Latched code released -> IDLE.
  - A different request appearing while in HOLD/REPEAT is ignored until the latched code is released.
- Latency: registered request to word change is 1 cycle. Total from input pin to output word is 2 cycles. Update is asserted in the same cycle as the new word.
- Frequency arithmetic: computed at W+1 bits.
  - Add: result > FTW_MAX -> FreqWord=FTW_MAX.
  - Sub: result < FTW_MIN (including borrow) -> FreqWord=FTW_MIN.
  - Update pulses only if the value actually changed, so there is no pulse when pinned at a bound.
- Phase arithmetic: modulo 2^W, wraps freely, Update pulses on every step.
- Saturated: registered compare of the new FreqWord against the bounds.
- Reset asserted mid-hold: immediate return to reset values. After release, a request still held is treated as a fresh press.

Decomposition:
- Package dds_pkg:
  - request-code enum (NONE, C_UP, C_DN, M_UP, M_DN, N_UP, N_DN, P_UP, P_DN)
  - FSM state enum (IDLE, HOLD, REPEAT)
  - default step constants
- Sub-module dds_step_alu: combinational; takes code, FreqWord and PhaseWord; returns next words and changed flag, including saturation.
- The top holds the input register, FSM, counter and output registers.

Test Plan:
- Reset, then pulse SwitchNanoadd low 1 cycle -> 2 cycles later FreqWord=42950+430=43380, Update high exactly 1 cycle.
- Hold Switchadd low for HOLD_CYC+2*REP_CYC cycles (shrink to HOLD_CYC=10, REP_CYC=4 in the bench) -> exactly 3 coarse steps applied, one at press and one at each expiry.
- FreqWord=FTW_MAX-100, press Switchadd -> FreqWord=FTW_MAX, Saturated=1. Press again -> no change, Update stays 0.
- PhaseWord=32'hFE00_0000, press Phaseadd 3 times -> sequence 32'h0200_0000, 32'h0600_0000, 32'h0A00_0000 after the wrap.
- Switchsub and SwitchNanoadd low in the same cycle -> only coarse down is applied (FreqWord saturates to FTW_MIN=1 from reset value).
- Assert reset during REPEAT with Switchadd held -> outputs return to reset values. After release, one step at 2 cycles, then a new HOLD delay.
